// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-way round-robin arbiter with registered one-hot grant.
// Optional grant-hold timeout/preemption is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter_4 #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_range
    $error("rr_arbiter_4: HOLD_MAX must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;
  logic       owner_req;
  logic       do_grant;
  logic       do_drop;
  logic       do_preempt;

  // Scan from the farthest slot back to ptr so the nearest asserted request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    cand      = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign owner_req = req[gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       hold_full;

  assign hold_full  = (hold_cnt == 8'(HOLD_MAX));
  assign do_preempt = en && (state == GRANT) && owner_req && hold_full &&
                      (|(req & ~gnt));
`else
  assign do_preempt = 1'b0;
`endif

  assign do_grant = en && win_found && ((state == IDLE) || !owner_req);
  assign do_drop  = !en || ((state == GRANT) && !owner_req && !win_found);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end else if (do_grant) begin
      state     <= GRANT;
      ptr       <= win_idx + 2'd1;
      gnt       <= 4'b0001 << win_idx;
      gnt_idx   <= win_idx;
      gnt_valid <= 1'b1;
    end else if (do_drop || do_preempt) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      gnt_idx   <= 2'd0;
      gnt_valid <= 1'b0;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Counter saturates so a lone requester keeps its grant indefinitely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= 8'd0;
      preempt  <= 1'b0;
    end else begin
      preempt <= do_preempt;
      if (do_grant || do_drop || do_preempt) begin
        hold_cnt <= 8'd0;
      end else if ((state == GRANT) && !hold_full) begin
        hold_cnt <= hold_cnt + 8'd1;
      end
    end
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4 (HOLD_MAX=3).
// Timeout scenarios run when RR_ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int checks = 0;
  int errors = 0;

  // Each entry: {expected gnt, expected preempt}
  logic [4:0] exp_q[$];

  rr_arbiter_4 #(.HOLD_MAX(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Full observable output vector {gnt, gnt_idx, gnt_valid, preempt} for an entry.
  function automatic logic [7:0] expand(input logic [4:0] e);
    logic [1:0] idx;
    case (e[4:1])
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return {e[4:1], idx, |e[4:1], e[0]};
  endfunction

  task automatic cycle(input logic e, input logic [3:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    en    = 1'b0;
    req   = 4'b0000;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 4'b1111;
    #2;
    exp_q.push_back(5'b0000_0);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL reset_async got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    exp_q.push_back(5'b0000_0);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL reset_held got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [3:0] stim [4];
    logic [3:0] want [4];
    logic [4:0] e;
    stim = '{4'b0101, 4'b0100, 4'b0100, 4'b0000};
    want = '{4'b0001, 4'b0100, 4'b0100, 4'b0000};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({want[s], 1'b0});
      cycle(1'b1, stim[s]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL basic[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] stim [10];
    logic [3:0] want [10];
    logic [4:0] e;
    stim = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
             4'b1111, 4'b1011, 4'b1111, 4'b0111, 4'b1111};
    want = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
             4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      exp_q.push_back({want[s], 1'b0});
      cycle(1'b1, stim[s]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL rotation[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
      checks++;
      if ($countones(gnt) > 1) begin
        errors++;
        $display("FAIL rotation_onehot[%0d] got gnt=%b want at most one bit", s, gnt);
      end
    end
  endtask

  task automatic test_enable();
    logic       ens  [6];
    logic [3:0] stim [6];
    logic [3:0] want [6];
    logic [4:0] e;
    ens  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    stim = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b0000, 4'b0001};
    want = '{4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      exp_q.push_back({want[s], 1'b0});
      cycle(ens[s], stim[s]);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL enable[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [4:0] e;
    apply_reset();
    exp_q.push_back(5'b0010_0);
    cycle(1'b1, 4'b0010);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL midrst_grant got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(5'b0000_0);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL midrst_async got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exp_q.push_back(5'b0010_0);
    cycle(1'b1, 4'b1010);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL midrst_after got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
  endtask

  task automatic test_glitch();
    logic [4:0] e;
    apply_reset();
    exp_q.push_back(5'b0001_0);
    cycle(1'b1, 4'b0011);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL glitch_grant got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    exp_q.push_back(5'b0001_0);
    req = 4'b0010;
    #2;
    req = 4'b0011;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL glitch_hold got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
    exp_q.push_back(5'b0010_0);
    cycle(1'b1, 4'b0010);
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
      errors++;
      $display("FAIL glitch_drop got %b want %b", {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
    end
  endtask

  task automatic test_solo_hold();
    logic [4:0] e;
    apply_reset();
    for (int s = 0; s < 20; s++) begin
      exp_q.push_back(5'b0001_0);
      cycle(1'b1, 4'b0001);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL solo[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
    end
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [4:0] want [11];
    logic [4:0] e;
    want = '{5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0001_0, 5'b0000_1,
             5'b0010_0, 5'b0010_0, 5'b0010_0, 5'b0010_0, 5'b0000_1,
             5'b0001_0};
    apply_reset();
    for (int s = 0; s < 11; s++) begin
      exp_q.push_back(want[s]);
      cycle(1'b1, 4'b0011);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL timeout[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
    end
  endtask
`else
  task automatic test_no_timeout();
    logic [4:0] e;
    apply_reset();
    for (int s = 0; s < 20; s++) begin
      exp_q.push_back(5'b0001_0);
      cycle(1'b1, 4'b0011);
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== expand(e)) begin
        errors++;
        $display("FAIL no_timeout[%0d] got %b want %b", s, {gnt, gnt_idx, gnt_valid, preempt}, expand(e));
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_basic();
    test_rotation();
    test_enable();
    test_reset_mid_grant();
    test_glitch();
    test_solo_hold();
`ifdef RR_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
